// File: rtl/vproc_vreg_rd_seq_if.sv
// rtl/vproc_vreg_rd_seq_if.sv - request, register-file read and output beat signals of the vreg read sequencer
interface vproc_vreg_rd_seq_if #(
   parameter int VREG_W = 512,
   parameter int PORT_W = 128
);
   localparam int BEATS_PER_REG = VREG_W / PORT_W;
   localparam int PART_W        = (BEATS_PER_REG > 1) ? $clog2(BEATS_PER_REG) : 1;
   localparam int ADDR_W        = 5 + PART_W;

   logic              req_valid_i;
   logic              req_ready_o;
   logic [4:0]        req_vreg_i;
   logic [1:0]        req_emul_i;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [PORT_W-1:0] rd_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [PORT_W-1:0] out_data_o;
   logic              out_last_o;

   modport slave (
      input  req_valid_i, req_vreg_i, req_emul_i, rd_data_i, out_ready_i,
      output req_ready_o, rd_addr_o, out_valid_o, out_data_o, out_last_o
   );

   modport master (
      output req_valid_i, req_vreg_i, req_emul_i, rd_data_i, out_ready_i,
      input  req_ready_o, rd_addr_o, out_valid_o, out_data_o, out_last_o
   );
endinterface

// File: rtl/vproc_vreg_rd_seq.sv
// rtl/vproc_vreg_rd_seq.sv - streams a vector register group out of the register file one read-port beat at a time
module vproc_vreg_rd_seq #(
   parameter int VREG_W = 512,
   parameter int PORT_W = 128
) (
   input  logic                clk_i,
   input  logic                async_rst_ni,
   vproc_vreg_rd_seq_if.slave  bus
);
   localparam int BEATS_PER_REG = VREG_W / PORT_W;
   localparam int PART_W        = (BEATS_PER_REG > 1) ? $clog2(BEATS_PER_REG) : 1;
   localparam int ADDR_W        = 5 + PART_W;
   localparam int LOG_B         = $clog2(BEATS_PER_REG);
   // wide enough to hold the beat count of an 8-register group
   localparam int CNT_W         = $clog2(8 * BEATS_PER_REG) + 1;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e            state_q, state_d;
   logic [4:0]        vreg_q;
   logic [CNT_W-1:0]  beat_q;
   logic [CNT_W-1:0]  last_beat_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_busy;
   logic [4:0]        reg_off;
   logic [PART_W-1:0] part;
   logic              accept;
   logic              capture;
   logic              is_last;
   logic              req_ready;
   logic              out_valid_q;
   logic              out_last_q;
   logic [PORT_W-1:0] out_data_q;

   assign accept  = (state_q == IDLE) && bus.req_valid_i;
   // the single output slot may be refilled in the same cycle it drains
   assign capture = (state_q == BUSY) && (!out_valid_q || bus.out_ready_i);
   assign is_last = (beat_q == last_beat_q);

   // register index wraps mod 32 through the 5-bit add; part is the beat within one register
   assign reg_off   = 5'(beat_q >> LOG_B);
   assign part      = PART_W'(beat_q & CNT_W'(BEATS_PER_REG - 1));
   assign addr_busy = {vreg_q + reg_off, part};

   // idle keeps presenting the last address that was read
   assign bus.rd_addr_o   = (state_q == BUSY) ? addr_busy : addr_q;
   assign bus.req_ready_o = req_ready;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_last_o  = out_last_q;
   assign bus.out_data_o  = out_data_q;

   // state register
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) state_q <= IDLE;
      else               state_q <= state_d;
   end

   // next state and request handshake
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i) state_d = BUSY;
         end
         BUSY: begin
            if (capture && is_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // request latch, beat counter, address history and output slot
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         vreg_q      <= '0;
         beat_q      <= '0;
         last_beat_q <= '0;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (accept) begin
            vreg_q      <= bus.req_vreg_i;
            beat_q      <= '0;
            last_beat_q <= (CNT_W'(BEATS_PER_REG) << bus.req_emul_i) - CNT_W'(1);
         end
         if (capture) begin
            out_data_q  <= bus.rd_data_i;
            out_valid_q <= 1'b1;
            out_last_q  <= is_last;
            beat_q      <= beat_q + CNT_W'(1);
            addr_q      <= addr_busy;
         end else if (out_valid_q && bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vproc_vreg_rd_seq.sv
// tb/tb_vproc_vreg_rd_seq.sv - directed scoreboard bench for the vreg read sequencer
module tb_vproc_vreg_rd_seq;
   typedef struct {
      logic [127:0] data;
      logic         last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   beat_t exp_q[$];
   beat_t obs_q[$];

   vproc_vreg_rd_seq_if #(.VREG_W(512), .PORT_W(128)) bus ();

   vproc_vreg_rd_seq #(.VREG_W(512), .PORT_W(128)) dut (
      .clk_i        (clk),
      .async_rst_ni (rst_n),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] rf_data(logic [6:0] a);
      logic [31:0] w;
      w = {16'hC0DE, 9'h0, a};
      return {w, ~w, w ^ 32'h1357_9BDF, {w[15:0], w[31:16]}};
   endfunction

   function automatic logic [6:0] exp_addr(logic [4:0] vreg, int b);
      logic [4:0] r;
      logic [1:0] p;
      r = vreg + 5'(b / 4);
      p = 2'(b % 4);
      return {r, p};
   endfunction

   assign bus.rd_data_i = rf_data(bus.rd_addr_o);

   // record every beat that is handed off at the coming clock edge
   always @(negedge clk) begin
      if (rst_n && bus.out_valid_o && bus.out_ready_i)
         obs_q.push_back('{data: bus.out_data_o, last: bus.out_last_o});
   end

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [4:0] vreg, logic [1:0] emul);
      int n;
      check("req_ready_before_send", bus.req_ready_o, 1);
      n = (1 << emul) * 4;
      for (int b = 0; b < n; b++)
         exp_q.push_back('{data: rf_data(exp_addr(vreg, b)), last: (b == n - 1)});
      bus.req_valid_i = 1'b1;
      bus.req_vreg_i  = vreg;
      bus.req_emul_i  = emul;
      tick();
      bus.req_valid_i = 1'b0;
      bus.req_vreg_i  = 5'($urandom);
      bus.req_emul_i  = 2'($urandom);
   endtask

   task automatic compare_observed(inout int nbeats, inout int nlast);
      beat_t o, e;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         nbeats++;
         if (o.last) nlast++;
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", o.data, e.data);
            check("beat_last", o.last, e.last);
         end
      end
   endtask

   task automatic drain(input bit rand_ready, output int nbeats, output int nlast);
      bit done;
      nbeats = 0;
      nlast  = 0;
      done   = 1'b0;
      for (int c = 0; c < 2000 && !done; c++) begin
         if (rand_ready) bus.out_ready_i = 1'($urandom_range(0, 1));
         tick();
         compare_observed(nbeats, nlast);
         done = (exp_q.size() == 0) && !bus.out_valid_o && bus.req_ready_o;
      end
      if (!done) check("drain_timeout", 0, 1);
      bus.out_ready_i = 1'b1;
   endtask

   initial begin
      int nb, nl;
      bus.req_valid_i = 1'b0;
      bus.req_vreg_i  = '0;
      bus.req_emul_i  = '0;
      bus.out_ready_i = 1'b1;

      // reset state
      #1;
      check("rst_req_ready", bus.req_ready_o, 1);
      check("rst_out_valid", bus.out_valid_o, 0);
      check("rst_out_last", bus.out_last_o, 0);
      check("rst_out_data", bus.out_data_o, 0);
      check("rst_rd_addr", bus.rd_addr_o, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // single register, ready held high: address sequence and latency
      send(5'd5, 2'd0);
      check("r32_ready_busy", bus.req_ready_o, 0);
      check("r32_valid_k1", bus.out_valid_o, 0);
      check("r32_addr0", bus.rd_addr_o, {5'd5, 2'd0});
      tick();
      check("r32_valid_k2", bus.out_valid_o, 1);
      check("r32_last_b0", bus.out_last_o, 0);
      check("r32_addr1", bus.rd_addr_o, {5'd5, 2'd1});
      tick();
      check("r32_addr2", bus.rd_addr_o, {5'd5, 2'd2});
      tick();
      check("r32_addr3", bus.rd_addr_o, {5'd5, 2'd3});
      check("r32_ready_b3", bus.req_ready_o, 0);
      tick();
      check("r32_ready_back", bus.req_ready_o, 1);
      check("r32_last_b3", bus.out_last_o, 1);
      check("r32_addr_hold", bus.rd_addr_o, {5'd5, 2'd3});
      drain(1'b0, nb, nl);
      check("r32_beats", nb, 4);
      check("r32_lasts", nl, 1);

      // four-register group wrapping past register 31
      send(5'd30, 2'd2);
      drain(1'b0, nb, nl);
      check("r33_beats", nb, 16);
      check("r33_lasts", nl, 1);
      check("r33_last_addr", bus.rd_addr_o, {5'd1, 2'd3});

      // downstream stall after the first beat
      bus.out_ready_i = 1'b0;
      send(5'd9, 2'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("r34_valid_stall", bus.out_valid_o, 1);
         check("r34_data_stall", bus.out_data_o, rf_data({5'd9, 2'd0}));
         check("r34_addr_stall", bus.rd_addr_o, {5'd9, 2'd1});
         tick();
      end
      bus.out_ready_i = 1'b1;
      drain(1'b0, nb, nl);
      check("r34_beats", nb, 4);
      check("r34_lasts", nl, 1);

      // eight-register group under random backpressure
      send(5'd3, 2'd3);
      drain(1'b1, nb, nl);
      check("r35_beats", nb, 32);
      check("r35_lasts", nl, 1);

      // reset in the middle of a two-register group
      bus.out_ready_i = 1'b1;
      send(5'd10, 2'd1);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("r36_out_valid", bus.out_valid_o, 0);
      check("r36_out_last", bus.out_last_o, 0);
      check("r36_out_data", bus.out_data_o, 0);
      check("r36_rd_addr", bus.rd_addr_o, 0);
      check("r36_req_ready", bus.req_ready_o, 1);
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      obs_q.delete();
      tick();
      tick();
      tick();
      check("r36_no_resume_valid", bus.out_valid_o, 0);
      check("r36_no_resume_ready", bus.req_ready_o, 1);
      check("r36_no_resume_beats", obs_q.size(), 0);
      send(5'd7, 2'd0);
      drain(1'b0, nb, nl);
      check("r36_beats", nb, 4);
      check("r36_lasts", nl, 1);

      // back-to-back request while the previous last beat is still held
      nb = 0;
      nl = 0;
      send(5'd12, 2'd0);
      for (int c = 0; c < 20 && !bus.req_ready_o; c++) begin
         tick();
         compare_observed(nb, nl);
      end
      check("r37_ready_returned", bus.req_ready_o, 1);
      bus.out_ready_i = 1'b0;
      send(5'd20, 2'd0);
      for (int i = 0; i < 3; i++) begin
         check("r37_held_last", bus.out_last_o, 1);
         check("r37_held_data", bus.out_data_o, rf_data({5'd12, 2'd3}));
         tick();
      end
      bus.out_ready_i = 1'b1;
      begin
         int nb2, nl2;
         drain(1'b0, nb2, nl2);
         check("r37_beats", nb + nb2, 8);
         check("r37_lasts", nl + nl2, 2);
      end

      check("final_exp_empty", exp_q.size(), 0);
      check("final_obs_empty", obs_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
